// File: rtl/icb_csr_sram_bridge_if.sv
// ICB command/response bus between a host master and the CSR/SRAM bridge slave.
interface icb_csr_sram_bridge_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_csr_sram_bridge.sv
// ICB slave for the MHSA accelerator: CSR file plus a write-merging, read-capable
// port into the unified SRAM. 32-bit writes are packed into SRAM_DW-bit words.
module icb_csr_sram_bridge #(
  parameter int unsigned SRAM_DW    = 64,
  parameter int unsigned SRAM_AW    = 16,
  parameter logic [31:0] SRAM_BYTES = 32'h4000,
  parameter logic [31:0] CSR_BASE   = 32'h4000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  icb_csr_sram_bridge_if.slave   icb,
  output logic                   start_pulse,
  input  logic                   done_set,
  output logic [31:0]            input_base,
  output logic [31:0]            output_base,
  output logic [SRAM_AW-1:0]     sram_addr,
  output logic [SRAM_DW-1:0]     sram_wdata,
  output logic [SRAM_DW/8-1:0]   sram_be,
  output logic                   sram_we,
  output logic                   sram_re,
  input  logic [SRAM_DW-1:0]     sram_rdata
);

  localparam int unsigned K    = SRAM_DW / 32;
  localparam int unsigned BE_W = SRAM_DW / 8;
  localparam int unsigned B    = $clog2(BE_W);
  localparam int unsigned LW   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RSP} state_t;

  state_t state, state_next;

  logic [15:0]         off;
  logic [31:0]         off_ext;
  logic [31:0]         csr_rel;
  logic                sram_hit, csr_hit;
  logic [SRAM_AW-1:0]  word;
  logic [LW-1:0]       lane;
  logic                wr_last;
  logic                flush, hold, accept;

  logic [SRAM_DW-1:0]  buf_data, merged;
  logic [BE_W-1:0]     buf_be, merged_be;
  logic [SRAM_AW-1:0]  buf_word;
  logic                dirty;
  logic [SRAM_AW-1:0]  wr_addr;
  logic [LW-1:0]       rd_lane;
  logic                done;
  logic                done_clr;
  logic [31:0]         csr_rdata;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                unused_bits;

  function automatic logic [31:0] apply_mask(input logic [31:0] cur, input logic [31:0] wd,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++)
      if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  assign off      = icb.icb_cmd_addr[15:0];
  assign off_ext  = {16'h0, off};
  assign csr_rel  = off_ext - CSR_BASE;
  assign sram_hit = off_ext < SRAM_BYTES;
  assign csr_hit  = (off_ext >= CSR_BASE) && (off_ext < CSR_BASE + 32'd16);
  assign word     = off_ext[B+SRAM_AW-1:B];
  assign lane     = (K > 1) ? LW'(off >> 2) : '0;
  assign wr_last  = (lane == LW'(K - 1));

  assign unused_bits = ^{icb.icb_cmd_addr[31:16], off_ext, csr_rel};

  // A partial buffer is flushed before any SRAM read or a write to another word.
  // Reads additionally wait out a pending write strobe so we/re never overlap.
  assign flush  = icb.icb_cmd_valid & sram_hit & dirty & (icb.icb_cmd_read | (word != buf_word));
  assign hold   = flush | (icb.icb_cmd_valid & sram_hit & icb.icb_cmd_read & sram_we);
  assign accept = icb.icb_cmd_valid & icb.icb_cmd_ready;

  assign icb.icb_cmd_ready = (state == S_IDLE) & ~hold;
  assign icb.icb_rsp_valid = (state == S_RSP);
  assign icb.icb_rsp_rdata = rsp_rdata;
  assign icb.icb_rsp_err   = rsp_err;

  assign sram_re   = accept & sram_hit & icb.icb_cmd_read;
  assign sram_addr = sram_re ? word : wr_addr;

  assign done_clr = accept & csr_hit & ~icb.icb_cmd_read & (csr_rel[3:2] == 2'd1)
                    & icb.icb_cmd_wdata[0];

  always_comb begin
    merged = buf_data;
    for (int unsigned i = 0; i < 4; i++)
      if (icb.icb_cmd_wmask[i])
        merged[{lane, 2'(i), 3'b000} +: 8] = icb.icb_cmd_wdata[i*8 +: 8];
    merged_be = buf_be | (BE_W'(icb.icb_cmd_wmask) << {lane, 2'b00});
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_rel[3:2])
      2'd0:    csr_rdata = '0;
      2'd1:    csr_rdata = {30'h0, dirty, done};
      2'd2:    csr_rdata = input_base;
      default: csr_rdata = output_base;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = (sram_hit & icb.icb_cmd_read) ? S_READ : S_RSP;
      S_READ:  state_next = S_RSP;
      S_RSP:   if (icb.icb_rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data    <= '0;
      buf_be      <= '0;
      buf_word    <= '0;
      dirty       <= 1'b0;
      wr_addr     <= '0;
      sram_wdata  <= '0;
      sram_be     <= '0;
      sram_we     <= 1'b0;
      rd_lane     <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      start_pulse <= 1'b0;
      done        <= 1'b0;
      input_base  <= '0;
      output_base <= '0;
    end else begin
      sram_we     <= 1'b0;
      start_pulse <= 1'b0;
      done        <= done_set | (done & ~done_clr);

      if (state == S_READ) rsp_rdata <= sram_rdata[{rd_lane, 5'b00000} +: 32];

      if (flush) begin
        sram_we    <= 1'b1;
        wr_addr    <= buf_word;
        sram_wdata <= buf_data;
        sram_be    <= buf_be;
        buf_data   <= '0;
        buf_be     <= '0;
        dirty      <= 1'b0;
      end

      if (accept) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
        if (sram_hit) begin
          if (icb.icb_cmd_read) begin
            rd_lane <= lane;
          end else if (wr_last) begin
            sram_we    <= 1'b1;
            wr_addr    <= word;
            sram_wdata <= merged;
            sram_be    <= merged_be;
            buf_data   <= '0;
            buf_be     <= '0;
            dirty      <= 1'b0;
          end else begin
            buf_data <= merged;
            buf_be   <= merged_be;
            buf_word <= word;
            dirty    <= 1'b1;
          end
        end else if (csr_hit) begin
          if (icb.icb_cmd_read) begin
            rsp_rdata <= csr_rdata;
          end else begin
            unique case (csr_rel[3:2])
              2'd0:    start_pulse <= icb.icb_cmd_wdata[0];
              2'd2:    input_base  <= apply_mask(input_base, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
              2'd3:    output_base <= apply_mask(output_base, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
              default: ;
            endcase
          end
        end else begin
          rsp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icb_csr_sram_bridge.sv
// Directed bench for icb_csr_sram_bridge (SRAM_DW=64): merge, flush, read-back,
// CSR behaviour, error/backpressure and reset with a dirty buffer.
module tb_icb_csr_sram_bridge;
  localparam logic [31:0] CSR = 32'h4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_pulse, done_set;
  logic [31:0] input_base, output_base;
  logic [15:0] sram_addr;
  logic [63:0] sram_wdata, sram_rdata;
  logic [7:0]  sram_be;
  logic        sram_we, sram_re;

  icb_csr_sram_bridge_if bus ();

  icb_csr_sram_bridge #(.SRAM_DW(64), .SRAM_AW(16), .SRAM_BYTES(32'h4000), .CSR_BASE(32'h4000)) dut (
    .clk(clk), .rst_n(rst_n), .icb(bus),
    .start_pulse(start_pulse), .done_set(done_set),
    .input_base(input_base), .output_base(output_base),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_be(sram_be),
    .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [64] = '{default: '0};
  always @(posedge clk) begin
    if (sram_we)
      for (int b = 0; b < 8; b++)
        if (sram_be[b]) mem[sram_addr[5:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    if (sram_re) sram_rdata <= mem[sram_addr[5:0]];
  end

  int          we_cnt = 0, both_cnt = 0, start_cnt = 0, start_cyc = -1;
  logic [15:0] we_addr = '0;
  logic [63:0] we_data = '0;
  logic [7:0]  we_be = '0;
  always @(negedge clk) begin
    if (sram_we) begin
      we_cnt++;
      we_addr = sram_addr;
      we_data = sram_wdata;
      we_be   = sram_be;
    end
    if (sram_we && sram_re) both_cnt++;
    if (start_pulse) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          acc_cyc, rsp_cyc;
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat, r_stalls;

  task automatic xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input int rsp_hold, input logic with_done);
    int n;
    int bad;
    r_data = '0; r_err = 1'b0; r_lat = -1; r_stalls = 0;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = mask;
    bus.icb_rsp_ready = (rsp_hold == 0);
    #1;
    while (!bus.icb_cmd_ready && r_stalls < 40) begin
      @(negedge clk);
      r_stalls++;
    end
    if (!bus.icb_cmd_ready) begin
      check("cmd_accept", {63'h0, bus.icb_cmd_ready}, 64'd1);
      bus.icb_cmd_valid = 1'b0;
      bus.icb_rsp_ready = 1'b1;
      return;
    end
    acc_cyc = cyc;
    if (with_done) done_set = 1'b1;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    done_set = 1'b0;
    n = 0;
    while (!bus.icb_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.icb_rsp_valid) begin
      check("rsp_timeout", {63'h0, bus.icb_rsp_valid}, 64'd1);
      bus.icb_rsp_ready = 1'b1;
      return;
    end
    rsp_cyc = cyc;
    r_lat  = cyc - acc_cyc;
    r_data = bus.icb_rsp_rdata;
    r_err  = bus.icb_rsp_err;
    if (rsp_hold > 0) begin
      bad = 0;
      for (int i = 0; i < rsp_hold; i++) begin
        @(negedge clk);
        if (bus.icb_rsp_valid !== 1'b1 || bus.icb_rsp_rdata !== r_data ||
            bus.icb_rsp_err !== r_err || bus.icb_cmd_ready !== 1'b0) bad++;
      end
      check("bp_stable", 64'(bad), 64'd0);
      bus.icb_rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_set = 1'b1;
    @(negedge clk);
    done_set = 1'b0;
  endtask

  int we_before;

  initial begin
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b1;
    done_set = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_cmd_ready", {63'h0, bus.icb_cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'h0, bus.icb_rsp_valid}, 64'd0);
    check("rst_start", {63'h0, start_pulse}, 64'd0);
    check("rst_in_base", {32'h0, input_base}, 64'd0);
    check("rst_sram_we", {63'h0, sram_we}, 64'd0);

    // Two full lanes of word 2 merge into one SRAM write
    xfer(1'b0, 32'h10, 32'hAAAA_AAAA, 4'hF, 0, 1'b0);
    check("m1_lat", 64'(r_lat), 64'd1);
    check("m1_err", {63'h0, r_err}, 64'd0);
    check("m1_no_we", 64'(we_cnt), 64'd0);
    xfer(1'b0, 32'h14, 32'hBBBB_BBBB, 4'hF, 0, 1'b0);
    check("m2_rdata", {32'h0, r_data}, 64'd0);
    check("m2_we_cnt", 64'(we_cnt), 64'd1);
    check("m2_addr", {48'h0, we_addr}, 64'd2);
    check("m2_wdata", we_data, 64'hBBBB_BBBB_AAAA_AAAA);
    check("m2_be", {56'h0, we_be}, 64'hFF);

    // Partial write then a different word: flush with accumulated mask only
    xfer(1'b0, 32'h10, 32'h1122_3344, 4'h3, 0, 1'b0);
    check("p1_no_we", 64'(we_cnt), 64'd1);
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("p1_status_dirty", {32'h0, r_data}, 64'h2);
    xfer(1'b0, 32'h20, 32'h5566_7788, 4'hF, 0, 1'b0);
    check("p2_stall", 64'(r_stalls), 64'd1);
    check("p2_we_cnt", 64'(we_cnt), 64'd2);
    check("p2_addr", {48'h0, we_addr}, 64'd2);
    check("p2_be", {56'h0, we_be}, 64'h03);
    check("p2_wdata_lo", {48'h0, we_data[15:0]}, 64'h3344);
    xfer(1'b0, 32'h24, 32'h99AA_BBCC, 4'hF, 0, 1'b0);
    check("p3_addr", {48'h0, we_addr}, 64'd4);
    check("p3_wdata", we_data, 64'h99AA_BBCC_5566_7788);
    check("p3_be", {56'h0, we_be}, 64'hFF);

    // Read of a dirty word forces the flush first
    xfer(1'b0, 32'h18, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    xfer(1'b1, 32'h18, 32'h0, 4'h0, 0, 1'b0);
    check("rp_we_cnt", 64'(we_cnt), 64'd4);
    check("rp_addr", {48'h0, we_addr}, 64'd3);
    check("rp_be", {56'h0, we_be}, 64'h0F);
    check("rp_lat", 64'(r_lat), 64'd2);
    check("rp_rdata", {32'h0, r_data}, 64'hDEAD_BEEF);
    xfer(1'b1, 32'h24, 32'h0, 4'h0, 0, 1'b0);
    check("rd_lane1", {32'h0, r_data}, 64'h99AA_BBCC);
    xfer(1'b1, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("rd_partial_be", {32'h0, r_data}, 64'hAAAA_3344);
    xfer(1'b1, 32'h3FFC, 32'h0, 4'h0, 0, 1'b0);
    check("rd_top_err", {63'h0, r_err}, 64'd0);

    // CSR: start pulse, sticky done, W1C and set-wins
    xfer(1'b0, CSR, 32'h1, 4'hF, 0, 1'b0);
    check("start_cnt", 64'(start_cnt), 64'd1);
    check("start_cyc", 64'(start_cyc), 64'(rsp_cyc));
    xfer(1'b0, CSR, 32'h0, 4'hF, 0, 1'b0);
    check("start_none", 64'(start_cnt), 64'd1);
    xfer(1'b1, CSR, 32'h0, 4'h0, 0, 1'b0);
    check("ctrl_reads0", {32'h0, r_data}, 64'd0);
    pulse_done();
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("status_done", {32'h0, r_data}, 64'h1);
    xfer(1'b0, CSR + 32'h4, 32'h1, 4'hF, 0, 1'b0);
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("status_w1c", {32'h0, r_data}, 64'h0);
    xfer(1'b0, CSR + 32'h4, 32'h1, 4'hF, 0, 1'b1);
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("status_set_wins", {32'h0, r_data}, 64'h1);
    xfer(1'b0, CSR + 32'h8, 32'h1234_5678, 4'hF, 0, 1'b0);
    xfer(1'b0, CSR + 32'h8, 32'h00CD_0000, 4'h4, 0, 1'b0);
    check("in_base_port", {32'h0, input_base}, 64'h12CD_5678);
    xfer(1'b0, CSR + 32'hC, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    check("out_base_port", {32'h0, output_base}, 64'hCAFE_F00D);

    // Unmapped accesses and response backpressure
    xfer(1'b1, 32'h8000, 32'h0, 4'h0, 0, 1'b0);
    check("err_rd", {63'h0, r_err}, 64'd1);
    check("err_rdata", {32'h0, r_data}, 64'd0);
    check("err_lat", 64'(r_lat), 64'd1);
    we_before = we_cnt;
    xfer(1'b0, 32'h8000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    check("err_wr", {63'h0, r_err}, 64'd1);
    check("err_no_we", 64'(we_cnt), 64'(we_before));
    xfer(1'b1, CSR + 32'h10, 32'h0, 4'h0, 0, 1'b0);
    check("err_past_csr", {63'h0, r_err}, 64'd1);
    xfer(1'b1, CSR + 32'h8, 32'h0, 4'h0, 3, 1'b0);
    check("bp_rdata", {32'h0, r_data}, 64'h12CD_5678);

    // Reset with a dirty buffer: nothing is written, state is cleared
    xfer(1'b0, 32'h30, 32'h7777_7777, 4'hF, 0, 1'b0);
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("pre_rst_status", {32'h0, r_data}, 64'h3);
    we_before = we_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_we", 64'(we_cnt), 64'(we_before));
    check("rst_in_base2", {32'h0, input_base}, 64'd0);
    check("rst_out_base2", {32'h0, output_base}, 64'd0);
    xfer(1'b1, CSR + 32'h4, 32'h0, 4'h0, 0, 1'b0);
    check("rst_status", {32'h0, r_data}, 64'h0);
    xfer(1'b0, 32'h34, 32'h0102_0304, 4'hF, 0, 1'b0);
    check("post_rst_addr", {48'h0, we_addr}, 64'd6);
    check("post_rst_be", {56'h0, we_be}, 64'hF0);
    check("post_rst_wdata", we_data, 64'h0102_0304_0000_0000);

    check("we_re_excl", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icb_csr_sram_bridge.md
Name: icb_csr_sram_bridge

Overview:
- Parametrised ICB slave for the MHSA accelerator: control/status CSR file plus a write-merging, read-capable port into the unified SRAM (usram).
- Merges 32-bit ICB writes into SRAM_DW-bit SRAM words with byte enables, flushes partial words on address change, and supports SRAM read-back.
- Drives the start pulse and base addresses for the accelerator core; collects the core's done event.

Parameters:
SRAM_DW, 64, SRAM word width; multiple of 32, range 32..256; K = SRAM_DW/32 lanes, B = log2(SRAM_DW/8)
SRAM_AW, 16, SRAM word-address width
SRAM_BYTES, 32'h4000, SRAM window size in bytes, starting at offset 0
CSR_BASE, 32'h4000, byte offset of the CSR block (4 registers, 16 bytes)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_read  in  1  1 = read, 0 = write
icb_cmd_addr  in  32  byte address; only bits [15:0] decoded
icb_cmd_wdata  in  32  write data
icb_cmd_wmask  in  4  byte enables
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_rdata  out  32  read data
icb_rsp_err  out  1  unmapped-address error
start_pulse  out  1  one-cycle start to core
done_set  in  1  core completion pulse
input_base  out  32  CSR
output_base  out  32  CSR
sram_addr  out  SRAM_AW  word address
sram_wdata  out  SRAM_DW  write data
sram_be  out  SRAM_DW/8  byte enables
sram_we  out  1  write strobe, one cycle
sram_re  out  1  read strobe
sram_rdata  in  SRAM_DW  read data, valid 1 cycle after sram_re

Behaviour:
- Reset (async, rst_n=0): all outputs, CSRs, merge buffer, lane mask and flags cleared to 0.
- Decode, off = addr[15:0]:
  - SRAM hit when off < SRAM_BYTES; word = off[B+SRAM_AW-1:B], lane = off[B-1:2].
  - CSR hit when CSR_BASE <= off < CSR_BASE+16.
  - Otherwise unmapped.
- One outstanding transaction. Accept = valid & ready.
- icb_cmd_ready = !rsp_busy & !hold.
  - rsp_busy is set at accept and cleared on rsp_valid & rsp_ready.
  - hold = valid & SRAM hit & dirty & (read | word != buf_word). Combinational, may depend on valid.
- CSR map (offset from CSR_BASE):
  - 0x0 CTRL: write bit0=1 -> start_pulse high for exactly the cycle after accept; reads 0.
  - 0x4 STATUS: bit0 done is sticky, set by done_set, write-1-to-clear; set wins over a simultaneous clear. bit1 = dirty, read-only.
  - 0x8 INPUT_BASE, 0xC OUTPUT_BASE: RW, byte-masked by wmask.
- Response timing:
  - CSR, SRAM-write and unmapped: rsp_valid at T+1 after accept at T.
  - SRAM read: sram_re=1 combinationally at T, lane captured at T+1, rsp_valid at T+2.
  - rsp_rdata/rsp_err stay stable while rsp_valid & !rsp_ready.
  - Unmapped: rsp_err=1, rdata=0, no side effects.
  - Write responses: rdata=0.
- Merge buffer: buf_data[SRAM_DW], buf_be[SRAM_DW/8], buf_word, dirty.
  - An accepted SRAM write merges wdata into the lane under wmask, ORs the mask into buf_be, sets buf_word and dirty.
  - Writing lane K-1 completes the word: at T+1 sram_we=1 with addr=buf_word, wdata=merged, be=accumulated; buffer and dirty clear.
  - With K=1 every write commits directly.
- Flush on hold: during a hold cycle the bridge issues a registered flush of the partial buffer at the next edge (sram_we=1, be = accumulated mask only), clears dirty, then accepts the held command.
- Rewriting an already-written lane before completion overwrites the masked bytes.
- Each SRAM port strobe is one cycle. sram_we and sram_re are never high in the same cycle.

Test Plan:
- Merge, SRAM_DW=64: write 0x0000_0010 = 0xAAAA_AAAA mask F, then 0x0000_0014 = 0xBBBB_BBBB -> single sram_we, addr=2, wdata=0xBBBBBBBB_AAAAAAAA, be=0xFF; no sram_we after the first write.
- Partial flush: write 0x10 = 0x11223344 mask 0x3, then write 0x20 -> cmd_ready low one cycle; sram_we addr=2, be=0x03, wdata[15:0]=0x3344; the new word is then buffered.
- Read-after-partial: partial write to 0x18, then read 0x18 -> flush write first, then sram_re, rsp_valid two cycles after accept, rdata = written lane.
- CSR: write CTRL=1 -> start_pulse exactly one cycle. Pulse done_set, read STATUS=0x1. Write STATUS=1 -> reads 0. done_set coinciding with the W1C -> bit stays 1.
- Error and backpressure: read 0x8000 -> rsp_err=1, rdata=0. Hold rsp_ready=0 for 3 cycles -> rsp stable, cmd_ready low.
- Reset mid-merge: assert rst_n low with dirty buffer -> no sram_we, STATUS=0, input_base=0 after release.
